pc_sequencer: RTL and testbench

Control block that owns and sequences the 32-bit program counter of the datapath. Each cycle it selects the next fetch address from sequential (PC+4), branch, or jump sources, holds the PC on stall, and halts and resumes fetch. It enforces the instruction-memory address window by wrapping out-of-range addresses to the reset address. It sits between decode/hazard logic and instruction memory, and emits a flush pulse for the IF/ID stage.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer_next_mux.sv | 53 +++++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer shared types and constants.
// FSM state enum, word-alignment mask, PC increment.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_INC     = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Handshake bundle between decode/hazard logic and pc_sequencer.
// master: control producer; slave: the PC sequencer.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic        Stall;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Halt;
  logic        Resume;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Valid;
  logic        Flush;
  logic        AlignErr;
  logic        Halted;
  logic [31:0] FetchCount;

  modport master (
    output Stall, Branch, BranchTarget,
    output Jump, JumpTarget, Halt, Resume,
    input  PC, PCPlus4, Valid, Flush,
    input  AlignErr, Halted, FetchCount
  );

  modport slave (
    input  Stall, Branch, BranchTarget,
    input  Jump, JumpTarget, Halt, Resume,
    output PC, PCPlus4, Valid, Flush,
    output AlignErr, Halted, FetchCount
  );

endinterface

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC source select (jump > branch > stall > PC+4) with wrap/align.
// Ports: pc, jump/branch + targets, stall -> next_pc, redirect, align_err.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'd128,
  parameter logic [31:0] RESET_ADDR = 32'd0
) (
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        align_err
);

  // Force word alignment, then fold anything outside imem to reset.
  function automatic logic [31:0] wrap(
    input logic [31:0] a
  );
    logic [31:0] w;
    w = a & ALIGN_MASK;
    return (w >= ADDR_LIMIT) ? RESET_ADDR : w;
  endfunction

  always_comb begin
    next_pc   = wrap(pc + PC_INC);
    redirect  = 1'b0;
    align_err = 1'b0;
    // Overlapping selects are legal; order encodes priority.
    priority case (1'b1)
      jump: begin
        next_pc   = wrap(jump_target);
        redirect  = 1'b1;
        align_err = |jump_target[1:0];
      end
      branch: begin
        next_pc   = wrap(branch_target);
        redirect  = 1'b1;
        align_err = |branch_target[1:0];
      end
      stall: begin
        next_pc = pc;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT/RUN/HALT FSM, PC register, flush.
// Ports: Clk, Reset (async high), bus (pc_sequencer_if.slave).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'd128,
  parameter logic [31:0] RESET_ADDR = 32'd0
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  pc_state_e   state_q;
  pc_state_e   state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        flush_q;
  logic        flush_d;
  logic        aerr_q;
  logic        aerr_d;
  logic [31:0] cnt_q;

  logic        run;
  logic [31:0] mux_pc;
  logic        mux_redir;
  logic        mux_aerr;

  assign run = (state_q == RUN);

  // Controls are masked outside RUN, so in HALT the
  // mux yields wrap(PC+4), which is the resume target.
  pc_next_mux #(
    .ADDR_LIMIT (ADDR_LIMIT),
    .RESET_ADDR (RESET_ADDR)
  ) u_mux (
    .pc            (pc_q),
    .jump          (run & bus.Jump),
    .jump_target   (bus.JumpTarget),
    .branch        (run & bus.Branch),
    .branch_target (bus.BranchTarget),
    .stall         (run & bus.Stall),
    .next_pc       (mux_pc),
    .redirect      (mux_redir),
    .align_err     (mux_aerr)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    aerr_d  = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.Halt) begin
          state_d = HALT;
        end else begin
          pc_d    = mux_pc;
          flush_d = mux_redir;
          aerr_d  = mux_aerr;
        end
      end
      HALT: begin
        if (bus.Resume) begin
          state_d = RUN;
          pc_d    = mux_pc;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDR;
      flush_q <= 1'b0;
      aerr_q  <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      aerr_q  <= aerr_d;
      if (run) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign bus.PC         = pc_q;
  assign bus.PCPlus4    = pc_q + PC_INC;
  assign bus.Valid      = run;
  assign bus.Halted     = (state_q == HALT);
  assign bus.Flush      = flush_q;
  assign bus.AlignErr   = aerr_q;
  assign bus.FetchCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// Directed scenarios plus random traffic against a behavioural model.
module tb_pc_sequencer;

  logic Clk;
  logic Reset;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .ADDR_LIMIT (32'd128),
    .RESET_ADDR (32'd0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks;
  int n_fail;

  // Behavioural model
  bit          m_boot;
  bit          m_halt;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_flush;
  bit          m_aerr;

  function automatic logic [31:0] wrap_ref(
    input logic [31:0] a
  );
    logic [31:0] w;
    w = a - (a % 4);
    if (w >= 128) return 32'd0;
    return w;
  endfunction

  task automatic model_reset();
    m_boot  = 1;
    m_halt  = 0;
    m_pc    = 0;
    m_cnt   = 0;
    m_flush = 0;
    m_aerr  = 0;
  endtask

  task automatic model_step();
    bit running;
    logic [31:0] t;
    running = !m_boot && !m_halt;
    if (running) m_cnt = m_cnt + 1;
    m_flush = 0;
    m_aerr  = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (bus.Resume) begin
        m_halt = 0;
        m_pc   = wrap_ref(m_pc + 4);
      end
    end else if (bus.Halt) begin
      m_halt = 1;
    end else if (bus.Jump || bus.Branch) begin
      t       = bus.Jump ? bus.JumpTarget : bus.BranchTarget;
      m_pc    = wrap_ref(t);
      m_flush = 1;
      m_aerr  = (t % 4) != 0;
    end else if (!bus.Stall) begin
      m_pc = wrap_ref(m_pc + 4);
    end
  endtask

  function automatic logic [99:0] exp_vec();
    return {m_pc, m_pc + 32'd4, !m_boot && !m_halt,
            m_flush, m_aerr, m_halt, m_cnt};
  endfunction

  function automatic logic [99:0] dut_vec();
    return {bus.PC, bus.PCPlus4, bus.Valid, bus.Flush,
            bus.AlignErr, bus.Halted, bus.FetchCount};
  endfunction

  task automatic idle();
    bus.Stall        = 0;
    bus.Branch       = 0;
    bus.BranchTarget = 0;
    bus.Jump         = 0;
    bus.JumpTarget   = 0;
    bus.Halt         = 0;
    bus.Resume       = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    if (!Reset) model_step();
    #1;
  endtask

  task automatic run_to(input logic [31:0] target);
    int k;
    idle();
    k = 0;
    while (m_pc != target && k < 64) begin
      step();
      k++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL run_to got %h exp %h", dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.PC !== target) begin
      n_fail++;
      $display("FAIL run_to_timeout pc got %h exp %h", bus.PC, target);
    end
  endtask

  task automatic test_reset();
    idle();
    Reset = 1;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state got %h exp %h", dut_vec(), exp_vec());
    end
    Reset = 0;
    #2;
    n_checks++;
    if (bus.Valid !== 1'b0 || bus.PC !== 32'd0) begin
      n_fail++;
      $display("FAIL boot got valid=%b pc=%h exp valid=0 pc=0",
               bus.Valid, bus.PC);
    end
  endtask

  task automatic test_sequential();
    idle();
    for (int i = 0; i < 33; i++) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL seq[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.PC !== 32'd0 || bus.FetchCount !== 32'd32) begin
      n_fail++;
      $display("FAIL seq_wrap got pc=%h cnt=%0d exp pc=0 cnt=32",
               bus.PC, bus.FetchCount);
    end
  endtask

  task automatic test_stall_branch();
    run_to(32'h10);
    bus.Stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.PC !== 32'h10 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    bus.Branch       = 1;
    bus.BranchTarget = 32'h40;
    step();
    n_checks++;
    if (bus.PC !== 32'h40 || bus.Flush !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_branch got pc=%h flush=%b exp pc=40 flush=1",
               bus.PC, bus.Flush);
    end
    idle();
    step();
    n_checks++;
    if (bus.Flush !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL flush_pulse got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_jump_branch();
    idle();
    bus.Jump         = 1;
    bus.JumpTarget   = 32'h20;
    bus.Branch       = 1;
    bus.BranchTarget = 32'h60;
    step();
    n_checks++;
    if (bus.PC !== 32'h20 || bus.Flush !== 1'b1 || bus.AlignErr !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_wins got pc=%h flush=%b exp pc=20 flush=1",
               bus.PC, bus.Flush);
    end
    bus.Branch     = 0;
    bus.JumpTarget = 32'h7E;
    step();
    n_checks++;
    if (bus.PC !== 32'h7C || bus.AlignErr !== 1'b1 || bus.Flush !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_misalign got pc=%h aerr=%b exp pc=7c aerr=1",
               bus.PC, bus.AlignErr);
    end
    idle();
    step();
    n_checks++;
    if (bus.AlignErr !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL aerr_pulse got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_halt();
    logic [31:0] cnt0;
    run_to(32'h30);
    bus.Halt = 1;
    step();
    cnt0 = bus.FetchCount;
    n_checks++;
    if (bus.PC !== 32'h30 || bus.Valid !== 1'b0 || bus.Halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_enter got pc=%h v=%b h=%b exp pc=30 v=0 h=1",
               bus.PC, bus.Valid, bus.Halted);
    end
    idle();
    bus.Branch       = 1;
    bus.BranchTarget = 32'h40;
    bus.Jump         = 1;
    bus.JumpTarget   = 32'h08;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.PC !== 32'h30 || bus.FetchCount !== cnt0 ||
          dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL halt_hold[%0d] got %h exp %h",
                 i, dut_vec(), exp_vec());
      end
    end
    idle();
    bus.Resume = 1;
    step();
    n_checks++;
    if (bus.PC !== 32'h34 || bus.Valid !== 1'b1 || bus.Halted !== 1'b0 ||
        bus.Flush !== 1'b0) begin
      n_fail++;
      $display("FAIL resume got pc=%h v=%b h=%b exp pc=34 v=1 h=0",
               bus.PC, bus.Valid, bus.Halted);
    end
    idle();
  endtask

  task automatic test_async_reset();
    run_to(32'h5C);
    #2;
    Reset = 1;
    model_reset();
    #1;
    n_checks++;
    if (bus.PC !== 32'd0 || bus.Valid !== 1'b0 ||
        bus.FetchCount !== 32'd0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset got %h exp %h", dut_vec(), exp_vec());
    end
    @(posedge Clk);
    #1;
    Reset = 0;
    step();
    n_checks++;
    if (bus.Valid !== 1'b1 || bus.PC !== 32'd0 || bus.FetchCount !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset_run got v=%b pc=%h cnt=%0d exp v=1 pc=0 cnt=0",
               bus.Valid, bus.PC, bus.FetchCount);
    end
  endtask

  task automatic test_out_of_range();
    idle();
    bus.Branch       = 1;
    bus.BranchTarget = 32'h200;
    step();
    n_checks++;
    if (bus.PC !== 32'd0 || bus.Flush !== 1'b1 || bus.AlignErr !== 1'b0) begin
      n_fail++;
      $display("FAIL out_of_range got pc=%h f=%b a=%b exp pc=0 f=1 a=0",
               bus.PC, bus.Flush, bus.AlignErr);
    end
    idle();
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom % 4)
      0: return ($urandom % 32) * 4;
      1: return $urandom % 128;
      2: return $urandom;
      default: return 32'd120 + ($urandom % 16);
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.Stall        = ($urandom % 4) == 0;
      bus.Branch       = ($urandom % 6) == 0;
      bus.Jump         = ($urandom % 8) == 0;
      bus.Halt         = ($urandom % 25) == 0;
      bus.Resume       = ($urandom % 3) == 0;
      bus.BranchTarget = rand_target();
      bus.JumpTarget   = rand_target();
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got %h exp %h", i, dut_vec(), exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 0;
    idle();
    test_reset();
    test_sequential();
    test_stall_branch();
    test_jump_branch();
    test_halt();
    test_async_reset();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
